// File: rtl/pc_ras_unit.sv
// pc_ras_unit
// -----------
// Fetch-stage program counter with a circular return-address stack (RAS).
// Each rising edge loads pc from next_pc. next_pc is chosen by fixed
// priority: trap, stall, taken branch, predicted return, jump, and finally
// sequential (pc + INSTR_BYTES).
//
// Ports:
//   clk            clock; all state changes on the rising edge
//   reset          synchronous reset, active low
//   stall          hold pc; overridden only by trap
//   trap           redirect to TRAP_VECTOR
//   branch_taken   taken conditional branch, target on branch_tgt
//   jump           unconditional jump, target on jump_tgt
//   is_call        jump is a call: push pc + INSTR_BYTES
//   is_ret         jump is a return: pop the RAS and use its top as target
//   pc             registered fetch PC
//   next_pc        combinational PC loaded on the next edge
//   ras_empty      RAS holds no entries
//   ras_full       RAS holds RAS_DEPTH entries
//   ras_overflow   sticky; a push overwrote the oldest valid entry
//   ras_underflow  one-cycle pulse after a return found the RAS empty
//   misalign       (PC_MISALIGN_TRAP_EN only) one-cycle pulse after a
//                  misaligned branch/jump target was turned into a trap
//
// Build option PC_MISALIGN_TRAP_EN: when defined, a selected branch or jump
// target with nonzero bits [1:0] redirects to TRAP_VECTOR and pulses
// misalign. When undefined, target bits [1:0] are cleared.

module pc_ras_unit #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
   parameter int unsigned     INSTR_BYTES  = 4,
   parameter int unsigned     RAS_DEPTH    = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            trap,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_tgt,
   input  logic            jump,
   input  logic [XLEN-1:0] jump_tgt,
   input  logic            is_call,
   input  logic            is_ret,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] next_pc,
   output logic            ras_empty,
   output logic            ras_full,
   output logic            ras_overflow,
   output logic            ras_underflow
`ifdef PC_MISALIGN_TRAP_EN
   ,
   output logic            misalign
`endif
);

   localparam int unsigned   PW      = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned   CW      = $clog2(RAS_DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);
   localparam logic [XLEN-1:0] STEP  = XLEN'(INSTR_BYTES);
`ifndef PC_MISALIGN_TRAP_EN
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
`endif

   // ras_ptr is the next free slot, so the top entry sits at ras_ptr - 1.
   // The pointer wraps naturally because RAS_DEPTH is a power of two.
   logic [XLEN-1:0] ras_mem [RAS_DEPTH];
   logic [PW-1:0]   ras_ptr;
   logic [PW-1:0]   top_idx;
   logic [CW-1:0]   ras_count;

   logic [XLEN-1:0] seq_pc;
   logic [XLEN-1:0] ras_top;
   logic [XLEN-1:0] branch_sel;
   logic [XLEN-1:0] jump_sel;
   logic            jump_path;
   logic            do_push;
   logic            do_pop;
   logic            do_replace;
   logic            underflow_d;
`ifdef PC_MISALIGN_TRAP_EN
   logic            misalign_d;
`endif

   assign top_idx   = ras_ptr - PW'(1);
   assign ras_top   = ras_mem[top_idx];
   assign seq_pc    = pc + STEP;
   assign ras_empty = (ras_count == '0);
   assign ras_full  = (ras_count == DEPTH_C);

`ifdef PC_MISALIGN_TRAP_EN
   assign branch_sel = branch_tgt;
   assign jump_sel   = jump_tgt;
`else
   assign branch_sel = branch_tgt & ALIGN_MASK;
   assign jump_sel   = jump_tgt & ALIGN_MASK;
`endif

   // Next-PC priority selection. jump_path marks the cycles on which the
   // jump source actually wins; only those cycles may touch the RAS.
   always_comb begin
      next_pc   = seq_pc;
      jump_path = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_d = 1'b0;
`endif
      if (!reset) begin
         next_pc = RESET_VECTOR;
      end else if (trap) begin
         next_pc = TRAP_VECTOR;
      end else if (stall) begin
         next_pc = pc;
      end else if (branch_taken) begin
         next_pc = branch_sel;
`ifdef PC_MISALIGN_TRAP_EN
         if (branch_sel[1:0] != 2'b00) begin
            next_pc    = TRAP_VECTOR;
            misalign_d = 1'b1;
         end
`endif
      end else if (jump && is_ret && !ras_empty) begin
         next_pc   = ras_top;
         jump_path = 1'b1;
      end else if (jump) begin
         next_pc   = jump_sel;
         jump_path = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
         if (jump_sel[1:0] != 2'b00) begin
            next_pc    = TRAP_VECTOR;
            misalign_d = 1'b1;
            jump_path  = 1'b0;
         end
`endif
      end
   end

   // A call+ret pair on a non-empty stack swaps the top entry in place;
   // on an empty stack it degrades to an ordinary push.
   always_comb begin
      do_push     = jump_path && is_call && !(is_ret && !ras_empty);
      do_replace  = jump_path && is_call && is_ret && !ras_empty;
      do_pop      = jump_path && is_ret && !is_call && !ras_empty;
      underflow_d = jump_path && is_ret && !is_call && ras_empty;
   end

   // PC, stack pointer/count and status flags. When full, the push lands on
   // the oldest slot (ras_ptr already points there) and count stays put.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc            <= RESET_VECTOR;
         ras_ptr       <= '0;
         ras_count     <= '0;
         ras_overflow  <= 1'b0;
         ras_underflow <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
         misalign      <= 1'b0;
`endif
      end else begin
         pc            <= next_pc;
         ras_underflow <= underflow_d;
`ifdef PC_MISALIGN_TRAP_EN
         misalign      <= misalign_d;
`endif
         if (do_push) begin
            ras_ptr <= ras_ptr + PW'(1);
            if (ras_full) begin
               ras_overflow <= 1'b1;
            end else begin
               ras_count <= ras_count + CW'(1);
            end
         end else if (do_pop) begin
            ras_ptr   <= top_idx;
            ras_count <= ras_count - CW'(1);
         end
      end
   end

   // Stack storage needs no reset; entries are only read while count > 0.
   always_ff @(posedge clk) begin
      if (do_push) begin
         ras_mem[ras_ptr] <= seq_pc;
      end else if (do_replace) begin
         ras_mem[top_idx] <= seq_pc;
      end
   end

endmodule
